// File: rtl/cancel_order_pkg.sv
// Shared book types and widths for the order-book cancel path.
package cancel_order_pkg;

   localparam int ID_INDEX       = 7;
   localparam int PRICE_INDEX    = 15;
   localparam int QUANTITY_INDEX = 15;
   localparam int ADDRESS_INDEX  = 3;
   localparam int SIZE_INDEX     = 4;
   localparam int MAX_INDEX      = 15;
   localparam bit MAX            = 1'b1;

   typedef struct packed {
      logic [ID_INDEX:0]       id;
      logic [PRICE_INDEX:0]    price;
      logic [QUANTITY_INDEX:0] quantity;
   } book_entry;

   // Unsigned "is a better" test: larger for bids, smaller for asks.
   function automatic logic price_better(input logic is_max,
                                         input logic [PRICE_INDEX:0] a,
                                         input logic [PRICE_INDEX:0] b);
      return is_max ? (a > b) : (a < b);
   endfunction

endpackage

// File: rtl/cancel_order_best_price_scan.sv
// Running best-price accumulator: seed with the first price, then keep the better one.
module best_price_scan
   import cancel_order_pkg::*;
#(
   parameter bit IS_MAX = MAX
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_seed,
   input  logic [PRICE_INDEX:0] i_price,
   output logic [PRICE_INDEX:0] o_best_next,
   output logic [PRICE_INDEX:0] o_best
);

   logic [PRICE_INDEX:0] r_best;

   // Candidate best including the price presented this cycle.
   always_comb begin
      o_best_next = r_best;
      if (i_seed || price_better(IS_MAX, i_price, r_best)) begin
         o_best_next = i_price;
      end
   end

   // Accumulate only on accepted samples.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_best <= '0;
      end else if (i_en) begin
         r_best <= o_best_next;
      end
   end

   assign o_best = r_best;

endmodule

// File: rtl/cancel_order.sv
// Removes an order by id from a dense book, back-fills the hole, and rescans for best price.
module cancel_order
   import cancel_order_pkg::*;
#(
   parameter bit IS_MAX = MAX
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start,
   input  logic [ID_INDEX:0]     order_id,
   input  logic [SIZE_INDEX:0]   size,
   output logic [ADDRESS_INDEX:0] addr,
   output logic                  mem_start,
   output logic                  is_write,
   output book_entry             data_w,
   input  book_entry             data_r,
   input  logic                  valid,
   output logic                  ready,
   output logic                  found,
   output book_entry             removed_entry,
   output logic [SIZE_INDEX:0]   size_update_o,
   output logic [PRICE_INDEX:0]  best_price_o,
   output logic                  price_valid_o
);

   localparam int SizeW = SIZE_INDEX + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEARCH, S_READ_LAST, S_WRITE_HOLE, S_RESCAN_INIT, S_RESCAN, S_DONE
   } state_t;

   state_t                r_state;
   logic [ID_INDEX:0]     r_id;
   logic [SIZE_INDEX:0]   r_n;
   logic [ADDRESS_INDEX:0] r_idx;
   logic [ADDRESS_INDEX:0] r_hole;

   logic [SIZE_INDEX:0]   w_n_m1;
   logic [SIZE_INDEX:0]   w_n_m2;
   logic [SIZE_INDEX:0]   w_idx_ext;
   logic                  w_done;
   logic                  w_hit;
   logic                  w_scan_en;
   logic                  w_scan_seed;
   logic [PRICE_INDEX:0]  w_best_next;
   logic [PRICE_INDEX:0]  w_best;

   assign w_n_m1    = r_n - SizeW'(1);
   assign w_n_m2    = r_n - SizeW'(2);
   assign w_idx_ext = SizeW'(r_idx);
   // A completion in the strobe cycle cannot belong to the current transaction.
   assign w_done      = valid & ~mem_start;
   assign w_hit       = (data_r.id == r_id);
   assign w_scan_en   = (r_state == S_RESCAN) && w_done;
   assign w_scan_seed = (r_idx == '0);

   best_price_scan #(
      .IS_MAX (IS_MAX)
   ) u_scan (
      .i_clk       (clk_in),
      .i_rst       (rst_in),
      .i_en        (w_scan_en),
      .i_seed      (w_scan_seed),
      .i_price     (data_r.price),
      .o_best_next (w_best_next),
      .o_best      (w_best)
   );

   // Control FSM with registered memory strobes and results.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state       <= S_IDLE;
         r_id          <= '0;
         r_n           <= '0;
         r_idx         <= '0;
         r_hole        <= '0;
         addr          <= '0;
         mem_start     <= 1'b0;
         is_write      <= 1'b0;
         data_w        <= '0;
         ready         <= 1'b0;
         found         <= 1'b0;
         removed_entry <= '0;
         size_update_o <= '0;
         best_price_o  <= '0;
         price_valid_o <= 1'b0;
      end else begin
         mem_start <= 1'b0;
         ready     <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_id  <= order_id;
                  r_n   <= size;
                  found <= 1'b0;
                  if (size == '0) begin
                     size_update_o <= '0;
                     r_state       <= S_DONE;
                  end else begin
                     r_idx     <= '0;
                     addr      <= '0;
                     is_write  <= 1'b0;
                     mem_start <= 1'b1;
                     r_state   <= S_SEARCH;
                  end
               end
            end
            S_SEARCH: begin
               if (w_done) begin
                  if (w_hit) begin
                     r_hole        <= r_idx;
                     removed_entry <= data_r;
                     found         <= 1'b1;
                     size_update_o <= w_n_m1;
                     if (w_idx_ext == w_n_m1) begin
                        r_state <= S_RESCAN_INIT;
                     end else begin
                        addr      <= w_n_m1[ADDRESS_INDEX:0];
                        is_write  <= 1'b0;
                        mem_start <= 1'b1;
                        r_state   <= S_READ_LAST;
                     end
                  end else if (w_idx_ext == w_n_m1) begin
                     size_update_o <= r_n;
                     r_state       <= S_DONE;
                  end else begin
                     r_idx     <= r_idx + 1'b1;
                     addr      <= r_idx + 1'b1;
                     is_write  <= 1'b0;
                     mem_start <= 1'b1;
                  end
               end
            end
            S_READ_LAST: begin
               if (w_done) begin
                  addr      <= r_hole;
                  data_w    <= data_r;
                  is_write  <= 1'b1;
                  mem_start <= 1'b1;
                  r_state   <= S_WRITE_HOLE;
               end
            end
            S_WRITE_HOLE: begin
               if (w_done) begin
                  r_state <= S_RESCAN_INIT;
               end
            end
            S_RESCAN_INIT: begin
               is_write <= 1'b0;
               if (w_n_m1 == '0) begin
                  best_price_o  <= '0;
                  price_valid_o <= 1'b0;
                  r_state       <= S_DONE;
               end else begin
                  r_idx     <= '0;
                  addr      <= '0;
                  mem_start <= 1'b1;
                  r_state   <= S_RESCAN;
               end
            end
            S_RESCAN: begin
               if (w_done) begin
                  if (w_idx_ext == w_n_m2) begin
                     best_price_o  <= w_best_next;
                     price_valid_o <= 1'b1;
                     r_state       <= S_DONE;
                  end else begin
                     r_idx     <= r_idx + 1'b1;
                     addr      <= r_idx + 1'b1;
                     mem_start <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               ready   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The registered accumulator value is only consumed through w_best_next.
   logic w_unused;
   assign w_unused = ^w_best;

endmodule
